alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit ALU control code from the ALU decoder and the two operands.
//  It produces a result word plus a single comparison/branch flag.
//  Single-cycle ops take 1 cycle. Shifts use an iterative shifter, SHIFT_STEP bits per cycle.
//  valid/ready on both sides lets the control path stall or flush it.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; power of 2, >=8; shamt = in_b[$clog2(DATA_WIDTH)-1:0]
//  SHIFT_STEP   1  max bit positions shifted per cycle; power of 2, 1..DATA_WIDTH
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst_n       in   1           synchronous active-low reset
//  flush       in   1           sync abort of in-flight op (branch redirect)
//  in_valid    in   1           operands/ctrl valid
//  in_ready    out  1           unit can accept an op this cycle
//  in_a        in   DATA_WIDTH  operand A (rs1)
//  in_b        in   DATA_WIDTH  operand B (rs2/imm)
//  in_ctrl     in   4           ALU control code (table below)
//  out_valid   out  1           out_result/out_flag valid
//  out_ready   in   1           consumer takes result this cycle
//  out_result  out  DATA_WIDTH  result
//  out_flag    out  1           comparison/branch outcome
//  busy        out  1           high in SHIFT state
// BEHAVIOUR
//  ctrl: 0000 a+b | 0001 b (lui) | 0010 a&b | 0011 a|b | 0100 a^b | 0101 sll | 0110 srl | 0111 sra
//    1010 a-b | 1000 beq | 1001 bne | 1100 blt/slt (signed) | 1101 bge (signed) | 1110 bltu/sltu | 1111 bgeu
//  Flag codes (1000,1001,1100,1101,1110,1111): out_flag=outcome, out_result={0..,outcome}.
//  All other codes: out_flag=0. Reserved 1011 -> result 0, flag 0 (no error).
//  add/sub wrap mod 2^DATA_WIDTH. sra fills with in_a[MSB]. Only low $clog2(W) bits of in_b form shamt.
//  FSM IDLE / SHIFT / DONE. Accept = in_valid & in_ready at a rising edge.
//  in_ready = (IDLE) | (DONE & out_ready); low in SHIFT and during reset/flush.
//  On accept, latch in_a/in_b/in_ctrl:
//    non-shift, or shamt==0 -> compute, go DONE (out_valid high the next cycle, latency 1)
//    shift with shamt>0 -> work=in_a, rem=shamt, go SHIFT
//  SHIFT: each edge shifts work by k=min(SHIFT_STEP,rem), rem-=k; at rem==0 go DONE.
//    out_valid rises N=ceil(shamt/SHIFT_STEP) cycles after the 1-cycle case.
//  DONE: out_valid=1; out_result/out_flag held stable until out_ready.
//    out_ready & in_valid -> accept new op same edge (back-to-back, no bubble).
//    out_ready & !in_valid -> IDLE. !out_ready -> stay DONE, in_ready=0.
//  out_valid is low in IDLE and SHIFT. Results are never dropped or duplicated.
//  flush=1 at an edge -> IDLE, drop any op (incl. DONE result), no accept that edge.
//    out_valid=0 next cycle; out_result/out_flag keep their last value.
//  Priority: rst_n low > flush > handshake.
//  Reset (rst_n low at edge): state=IDLE, out_valid=0, out_result=0, out_flag=0, busy=0, rem=0.
//    Reset mid-SHIFT discards the op. in_ready=0 while rst_n low.
//  No combinational path from in_* to out_*; in_ready depends combinationally only on state and out_ready.
// TESTING
//  T1 add a=32'h7FFF_FFFF b=1 ctrl 0000 -> result 32'h8000_0000, flag 0, out_valid 1 cycle after accept
//  T2 SHIFT_STEP=1: sra a=32'h8000_0000 b=4 -> 32'hF800_0000 after 1+4 cycles
//     sll b=32 (shamt 0) -> a in 1 cycle; srl b=31 -> busy 31 cycles, result 1 for a=32'h8000_0000
//  T3 a=32'hFFFF_FFFF b=1: 1100 -> flag 1, result 1; 1110 -> flag 0, result 0
//     1000 a=b=5 -> flag 1; 1011 -> result 0, flag 0
//  T4 hold out_ready=0 3 cycles in DONE -> result stable, in_ready 0
//     then out_ready=1 & in_valid=1 same cycle -> new op accepted that edge, next out_valid 1 cycle later
//  T5 flush at 3rd cycle of SHIFT (srl shamt 20) -> IDLE next cycle, in_ready 1, no out_valid ever for that op
//     repeat with rst_n=0 -> all outputs 0
//  T6 lui ctrl 0001 b=32'h1234_5000 a=32'hFFFF_FFFF -> result 32'h1234_5000, flag 0
//     randomized ops vs reference model with random out_ready backpressure

Source files
------------

// File: rtl/alu_exec_if.sv
// alu_exec_if: valid/ready operand and result bundle for the execute-stage ALU
//   in_valid/in_ready/in_a/in_b/in_ctrl  op request into the unit
//   out_valid/out_ready/out_result/out_flag  result back to the consumer
//   busy  unit is in its multi-cycle shift state
interface alu_exec_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [3:0]            in_ctrl;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_flag;
  logic                  busy;
  modport master (
    output in_valid, in_a, in_b, in_ctrl, out_ready,
    input  in_ready, out_valid, out_result, out_flag, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, in_ctrl, out_ready,
    output in_ready, out_valid, out_result, out_flag, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle ops and an iterative shifter
//   clk, rst_n (sync, active low), flush (sync abort of in-flight op)
//   io: alu_exec_if slave (operand handshake in, result/flag handshake out, busy)
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  alu_exec_if.slave  io
);
  localparam int SW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d, result_q, result_d;
  logic [SW-1:0]         rem_q, rem_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic                  flag_q, flag_d;
  logic [DATA_WIDTH-1:0] alu_res, shifted, sra_v;
  logic                  alu_flag, eq, lt, ltu, is_flag, is_shift, accept;
  logic [SW-1:0]         shamt, k;
  always_comb begin
    eq       = io.in_a == io.in_b;
    lt       = $signed(io.in_a) < $signed(io.in_b);
    ltu      = io.in_a < io.in_b;
    // flag codes are 1000/1001 and 11xx; bit0 inverts the base compare
    is_flag  = io.in_ctrl[3] & (io.in_ctrl[2] | ~io.in_ctrl[1]);
    alu_flag = is_flag & ((io.in_ctrl[2] ? (io.in_ctrl[1] ? ltu : lt) : eq) ^ io.in_ctrl[0]);
    is_shift = io.in_ctrl == 4'b0101 || io.in_ctrl == 4'b0110 || io.in_ctrl == 4'b0111;
    shamt    = io.in_b[SW-1:0];
    case (io.in_ctrl)
      4'b0000: alu_res = io.in_a + io.in_b;
      4'b0001: alu_res = io.in_b;
      4'b0010: alu_res = io.in_a & io.in_b;
      4'b0011: alu_res = io.in_a | io.in_b;
      4'b0100: alu_res = io.in_a ^ io.in_b;
      4'b0101, 4'b0110, 4'b0111: alu_res = io.in_a;
      4'b1010: alu_res = io.in_a - io.in_b;
      default: alu_res = DATA_WIDTH'(alu_flag);
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    flag_d   = flag_q;
    // SHIFT_STEP may equal DATA_WIDTH, so compare at full int width
    k        = (32'(rem_q) > SHIFT_STEP) ? SW'(SHIFT_STEP) : rem_q;
    sra_v    = $signed(work_q) >>> k;
    shifted  = ctrl_q == 4'b0101 ? work_q << k : ctrl_q == 4'b0110 ? work_q >> k : sra_v;
    accept   = io.in_valid & io.in_ready;
    if (flush) state_d = IDLE;
    else if (accept) begin
      ctrl_d = io.in_ctrl;
      if (is_shift && shamt != '0) begin
        work_d  = io.in_a;
        rem_d   = shamt;
        state_d = SHIFT;
      end else begin
        result_d = alu_res;
        flag_d   = alu_flag;
        state_d  = DONE;
      end
    end else if (state_q == SHIFT) begin
      work_d = shifted;
      rem_d  = rem_q - k;
      if (rem_q == k) begin
        result_d = shifted;
        flag_d   = 1'b0;
        state_d  = DONE;
      end
    end else if (state_q == DONE && io.out_ready) state_d = IDLE;
  end
  always_comb begin
    io.in_ready   = rst_n & ~flush & (state_q == IDLE || (state_q == DONE && io.out_ready));
    io.out_valid  = state_q == DONE;
    io.busy       = state_q == SHIFT;
    io.out_result = result_q;
    io.out_flag   = flag_q;
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 0, rst_n = 0, flush = 0;
  always #5 clk = ~clk;
  alu_exec_if #(.DATA_WIDTH(32)) io();
  alu_exec_unit #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .io(io));
  typedef struct packed {logic [31:0] r; logic f;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [31:0] r;
    logic        f;
    logic [4:0]  sh;
    sh = b[4:0];
    f  = 1'b0;
    r  = '0;
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = $signed(a) >>> sh;
      4'd10: r = a - b;
      4'd8:  f = a == b;
      4'd9:  f = a != b;
      4'd12: f = $signed(a) < $signed(b);
      4'd13: f = $signed(a) >= $signed(b);
      4'd14: f = a < b;
      4'd15: f = a >= b;
      default: r = '0;
    endcase
    if (c == 4'd8 || c == 4'd9 || c >= 4'd12) r = {31'b0, f};
    return {r, f};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    exp_t e;
    #2;
    if (!rst_n || flush) sb.delete();
    else begin
      if (io.out_valid && io.out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_result", io.out_result, e.r);
          chk("sb_flag", 32'(io.out_flag), 32'(e.f));
        end
      end
      if (io.in_valid && io.in_ready) sb.push_back(model(io.in_a, io.in_b, io.in_ctrl));
    end
    @(posedge clk);
    #1;
  endtask
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                    input logic [31:0] er, input logic ef, input int lat);
    int n = 0, nb = 0;
    io.in_valid = 1; io.in_a = a; io.in_b = b; io.in_ctrl = c; io.out_ready = 1;
    #1 chk({tag, "_in_ready"}, 32'(io.in_ready), 1);
    cyc();
    io.in_valid = 0;
    while (!io.out_valid && n < 100) begin
      if (io.busy) nb++;
      cyc();
      n++;
    end
    chk({tag, "_valid"}, 32'(io.out_valid), 1);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_cycles"}, nb, lat);
    chk({tag, "_result"}, io.out_result, er);
    chk({tag, "_flag"}, 32'(io.out_flag), 32'(ef));
    cyc();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, acc, cycles;
    logic fired;
    io.in_valid = 0; io.in_a = 0; io.in_b = 0; io.in_ctrl = 0; io.out_ready = 1;
    cyc(); cyc();
    chk("rst_valid", 32'(io.out_valid), 0);
    chk("rst_result", io.out_result, 0);
    chk("rst_flag", 32'(io.out_flag), 0);
    chk("rst_busy", 32'(io.busy), 0);
    chk("rst_in_ready", 32'(io.in_ready), 0);
    rst_n = 1;
    #1 chk("idle_in_ready", 32'(io.in_ready), 1);
    cyc();
    op("t1_add", 32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000, 0, 0);
    op("t2_sra", 32'h8000_0000, 32'd4, 4'b0111, 32'hF800_0000, 0, 4);
    op("t2_sll0", 32'h1234_5678, 32'd32, 4'b0101, 32'h1234_5678, 0, 0);
    op("t2_srl31", 32'h8000_0000, 32'd31, 4'b0110, 32'd1, 0, 31);
    op("t2_sll3", 32'h0000_00F1, 32'd3, 4'b0101, 32'h0000_0788, 0, 3);
    op("t3_slt", 32'hFFFF_FFFF, 32'd1, 4'b1100, 32'd1, 1, 0);
    op("t3_sltu", 32'hFFFF_FFFF, 32'd1, 4'b1110, 32'd0, 0, 0);
    op("t3_bge", 32'hFFFF_FFFF, 32'd1, 4'b1101, 32'd0, 0, 0);
    op("t3_bgeu", 32'hFFFF_FFFF, 32'd1, 4'b1111, 32'd1, 1, 0);
    op("t3_beq", 32'd5, 32'd5, 4'b1000, 32'd1, 1, 0);
    op("t3_bne", 32'd5, 32'd5, 4'b1001, 32'd0, 0, 0);
    op("t3_rsvd", 32'd7, 32'd3, 4'b1011, 32'd0, 0, 0);
    op("t3_sub", 32'd0, 32'd1, 4'b1010, 32'hFFFF_FFFF, 0, 0);
    op("t3_and", 32'hF0F0_1234, 32'h0FF0_FF00, 4'b0010, 32'h00F0_1200, 0, 0);
    op("t6_lui", 32'hFFFF_FFFF, 32'h1234_5000, 4'b0001, 32'h1234_5000, 0, 0);
    io.in_valid = 1; io.in_a = 3; io.in_b = 4; io.in_ctrl = 4'b0000; io.out_ready = 0;
    cyc();
    io.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", 32'(io.out_valid), 1);
      chk("t4_hold_result", io.out_result, 32'd7);
      chk("t4_hold_in_ready", 32'(io.in_ready), 0);
      cyc();
    end
    io.out_ready = 1; io.in_valid = 1; io.in_a = 10; io.in_b = 6; io.in_ctrl = 4'b0100;
    #1 chk("t4_b2b_in_ready", 32'(io.in_ready), 1);
    cyc();
    io.in_valid = 0;
    chk("t4_b2b_valid", 32'(io.out_valid), 1);
    chk("t4_b2b_result", io.out_result, 32'd12);
    cyc();
    io.in_valid = 1; io.in_a = 32'h8000_0000; io.in_b = 20; io.in_ctrl = 4'b0110;
    cyc();
    io.in_valid = 0;
    cyc(); cyc();
    chk("t5_busy_before", 32'(io.busy), 1);
    flush = 1;
    cyc();
    flush = 0;
    #1;
    chk("t5_valid", 32'(io.out_valid), 0);
    chk("t5_busy", 32'(io.busy), 0);
    chk("t5_in_ready", 32'(io.in_ready), 1);
    chk("t5_keep_result", io.out_result, 32'd12);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (io.out_valid) n++;
      cyc();
    end
    chk("t5_no_output", n, 0);
    io.in_valid = 1; io.in_a = 1; io.in_b = 1; io.in_ctrl = 4'b0000; io.out_ready = 0;
    cyc();
    io.in_a = 9; flush = 1;
    #1 chk("flush_in_ready", 32'(io.in_ready), 0);
    cyc();
    flush = 0; io.in_valid = 0; io.out_ready = 1;
    chk("flush_done_drop", 32'(io.out_valid), 0);
    chk("flush_done_keep", io.out_result, 32'd2);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (io.out_valid) n++;
      cyc();
    end
    chk("flush_no_accept", n, 0);
    io.in_valid = 1; io.in_a = 32'h8000_0000; io.in_b = 20; io.in_ctrl = 4'b0110;
    cyc();
    io.in_valid = 0;
    cyc(); cyc();
    rst_n = 0;
    cyc();
    chk("t5r_valid", 32'(io.out_valid), 0);
    chk("t5r_result", io.out_result, 0);
    chk("t5r_flag", 32'(io.out_flag), 0);
    chk("t5r_busy", 32'(io.busy), 0);
    chk("t5r_in_ready", 32'(io.in_ready), 0);
    rst_n = 1;
    #1 chk("t5r_in_ready_after", 32'(io.in_ready), 1);
    cyc();
    acc = 0; cycles = 0; fired = 0;
    while (acc < 150 && cycles < 20000) begin
      if (!io.in_valid || fired) begin
        io.in_valid = 1'($urandom_range(0, 1));
        io.in_a     = $urandom;
        io.in_b     = $urandom_range(0, 1) != 0 ? $urandom : $urandom_range(0, 40);
        io.in_ctrl  = 4'($urandom_range(0, 15));
      end
      io.out_ready = $urandom_range(0, 3) != 0;
      #1 fired = io.in_valid && io.in_ready;
      if (fired) acc++;
      cyc();
      cycles++;
    end
    io.in_valid = 0; io.out_ready = 1;
    cycles = 0;
    while (sb.size() != 0 && cycles < 200) begin
      cyc();
      cycles++;
    end
    chk("rand_accepts", acc, 150);
    chk("rand_drain", sb.size(), 0);
    cyc();
    chk("rand_idle_valid", 32'(io.out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
